// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle adder/subtractor for the FPU datapath. Each RUN cycle adds
//   DIGIT bits, working from the LSB upward, so a WIDTH-bit operation takes
//   N = WIDTH/DIGIT cycles. Subtraction is a + ~b + ~cin. The borrow-in is
//   inverted into a carry-in, so cout=1 means "no borrow". WIDTH must be a
//   multiple of DIGIT.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. A producer holds valid and its data until that edge.
//   in_ready is high only in IDLE. in_valid in any other state is ignored.
//   out_valid stays high, and sum/cout/ovf stay stable, until out_ready is seen.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands/mode valid
//   in_ready   out  1      accepting operands (state == IDLE)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin, 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry-out (sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow
//   dbg_state  out  2      FSM state: 0 IDLE, 1 RUN, 2 DONE
// -----------------------------------------------------------------------------
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r;     // b_r already holds ~b for subtract
    logic             c_r;          // running carry between digits
    logic             last;
    logic [DIGIT-1:0] a_dig, b_dig, s_dig;
    logic [DIGIT:0]   cv;           // ripple carries; cv[DIGIT-1] enters the digit MSB
    logic [31:0]      shamt;
    logic [WIDTH-1:0] s_ins;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign last      = (cnt == LAST);

    // Operands shift right one digit per cycle, so the active digit is always
    // in the low bits. The result is placed at its final position instead, so
    // digits not computed yet read as zero.
    assign a_dig = a_r[DIGIT-1:0];
    assign b_dig = b_r[DIGIT-1:0];
    assign shamt = 32'(cnt) * 32'(DIGIT);
    assign s_ins = WIDTH'(s_dig) << shamt;

    // DIGIT-bit ripple of full-adder cells
    always_comb begin
        cv    = '0;
        s_dig = '0;
        cv[0] = c_r;
        for (int i = 0; i < DIGIT; i++) begin
            s_dig[i]  = a_dig[i] ^ b_dig[i] ^ cv[i];
            cv[i + 1] = (a_dig[i] & b_dig[i]) | (cv[i] & (a_dig[i] ^ b_dig[i]));
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state. out_valid is always high in DONE, so out_ready alone
    // completes the output handshake there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= sub ? ~b : b;
                        c_r <= sub ? ~cin : cin;
                        cnt <= '0;
                        sum <= '0;
                    end
                end
                RUN: begin
                    a_r <= a_r >> DIGIT;
                    b_r <= b_r >> DIGIT;
                    c_r <= cv[DIGIT];
                    sum <= sum | s_ins;
                    if (last) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        cout      <= cv[DIGIT];
                        ovf       <= cv[DIGIT] ^ cv[DIGIT-1];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// Bench for digit_serial_adder. Four instances with DIGIT = 4, 1, 8, 32 and
// WIDTH = 32. Instance 0 gets the directed cases. Every instance then gets
// random operations with back-pressure. Each result is checked against an
// integer model of a +/- b +/- cin.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

    localparam int W  = 32;
    localparam int NI = 4;

    logic                 clk;
    logic [NI-1:0]        rst_n, in_valid, in_ready, cin, sub;
    logic [NI-1:0]        out_valid, out_ready, cout, ovf;
    logic [NI-1:0][W-1:0] a, b, sum;
    logic [NI-1:0][1:0]   dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
        digit_serial_adder #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a[g]),
            .b         (b[g]),
            .cin       (cin[g]),
            .sub       (sub[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum       (sum[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g]),
            .dbg_state (dbg[g])
        );
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic int dig(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to WIDTH bits.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        longint ux, uy, sx, sy, c1, ru, rs;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c1 = ci ? 64'sd1 : 64'sd0;
        if (!sb) begin
            ru = ux + uy + c1;
            rs = sx + sy + c1;
            co = (ru > 64'sh0000_0000_FFFF_FFFF);
        end else begin
            ru = ux - uy - c1;
            rs = sx - sy - c1;
            co = (ru >= 64'sd0);
        end
        s  = ru[W-1:0];
        ov = (rs > 64'sh7FFF_FFFF) || (rs < -64'sh8000_0000);
    endfunction

    // One full transaction on instance i, with hold cycles of back-pressure.
    task automatic run_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input int hold,
                          input logic [W-1:0] e_sum, input logic e_co, input logic e_ov,
                          input string tag);
        int k;
        int lat;
        int n;
        logic [W-1:0] e;
        n = W / dig(i);
        exp_q.push_back(e_sum);
        @(negedge clk);
        a[i] = x; b[i] = y; cin[i] = ci; sub[i] = sb; in_valid[i] = 1'b1;
        k = 0;
        while (!in_ready[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);                        // accept edge has passed
        in_valid[i] = 1'b0;
        a[i] = $urandom; b[i] = $urandom;      // late changes must not matter
        cin[i] = 1'($urandom_range(0, 1));
        sub[i] = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid[i] && lat < n + 4) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, W'(lat), W'(n));
        check({tag, "_state"}, W'(dbg[i]), W'(2));
        check({tag, "_sum"}, sum[i], e);
        check({tag, "_cout"}, W'(cout[i]), W'(e_co));
        check({tag, "_ovf"}, W'(ovf[i]), W'(e_ov));
        for (int h = 0; h < hold; h++) begin
            in_valid[i] = 1'b1;                // offered while DONE: ignored
            a[i] = $urandom;
            @(negedge clk);
            check({tag, "_hold_valid"}, W'(out_valid[i]), W'(1));
            check({tag, "_hold_ready"}, W'(in_ready[i]), W'(0));
            check({tag, "_hold_sum"}, sum[i], e);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        check({tag, "_rel_valid"}, W'(out_valid[i]), W'(0));
        check({tag, "_rel_ready"}, W'(in_ready[i]), W'(1));
        check({tag, "_rel_sum"}, sum[i], e);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] x, y, es;
        logic ci, sb, eco, eov, seen;
        int reps;

        rst_n = '0; in_valid = '0; out_ready = '0; cin = '0; sub = '0;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = '1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_in_ready", W'(in_ready[i]), W'(1));
            check("rst_out_valid", W'(out_valid[i]), W'(0));
            check("rst_sum", sum[i], '0);
            check("rst_cout", W'(cout[i]), W'(0));
            check("rst_ovf", W'(ovf[i]), W'(0));
            check("rst_state", W'(dbg[i]), W'(0));
        end

        // directed cases on the DIGIT=4 instance
        run_op(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        run_op(0, 32'd5,         32'd7,         1'b0, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, es, eco, eov);
        run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 5, es, eco, eov, "backpressure");

        // reset in the middle of RUN
        @(negedge clk);
        a[0] = 32'h1234_5678; b[0] = 32'h1111_1111; cin[0] = 1'b0; sub[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("run_clr_sum", sum[0], '0);
        repeat (2) @(negedge clk);
        check("run_partial_sum", sum[0], 32'h0000_0089);
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check("abort_out_valid", W'(out_valid[0]), W'(0));
        check("abort_sum", sum[0], '0);
        check("abort_in_ready", W'(in_ready[0]), W'(1));
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid[0];
        end
        check("abort_no_result", W'(seen), W'(0));
        run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 32'd7, 1'b0, 1'b0, "post_reset");

        // random operations on every instance
        for (int i = 0; i < NI; i++) begin
            reps = (i == 0) ? 200 : 1000;
            for (int r = 0; r < reps; r++) begin
                x  = $urandom;
                y  = $urandom;
                if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
                if ($urandom_range(0, 7) == 0) y = 32'hFFFF_FFFF;
                if ($urandom_range(0, 7) == 0) y = 32'h7FFF_FFFF;
                ci = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                model(x, y, ci, sb, es, eco, eov);
                run_op(i, x, y, ci, sb, $urandom_range(0, 3), es, eco, eov,
                       $sformatf("rnd_d%0d", dig(i)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
